// File: rtl/accum_sequencer.sv
// Sequencer for the 8-bit accumulator datapath.
// For each accepted start it runs: clear, load, N increments, then a check of
// the accumulator output against load_val + steps (mod 256).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; no accumulator controls asserted
// S_CLEAR | acc_clr pulsed
// S_LOAD  | acc_ld pulsed with acc_ip = captured load value
// S_COUNT | acc_inc asserted once per cycle while the step count runs out
// S_CHECK | accumulator output sampled and compared; done follows
module accum_sequencer (
  input  logic       i_clock,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_load_val,
  input  logic [7:0] i_steps,
  input  logic       i_abort,
  input  logic [7:0] i_acc_op,
  output logic       o_acc_clr,
  output logic       o_acc_ld,
  output logic       o_acc_inc,
  output logic [7:0] o_acc_ip,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic       o_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_COUNT = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_cnt;
  logic [7:0] r_ld;
  logic [7:0] r_expected;
  logic [7:0] r_result;
  logic       r_err;
  logic       r_done;
  logic       w_accept;
  logic       w_check_ok;

  // Start is only honoured from IDLE; abort has no meaning there.
  assign w_accept   = (r_state == S_IDLE) && i_start;
  // An abort landing in CHECK suppresses the sample and the done pulse.
  assign w_check_ok = (r_state == S_CHECK) && !i_abort;

  // State register.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore output decode; abort wins over every busy transition.
  always_comb begin
    w_next_state = r_state;
    o_acc_clr    = 1'b0;
    o_acc_ld     = 1'b0;
    o_acc_inc    = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        o_acc_clr = 1'b1;
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        o_acc_ld = 1'b1;
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == 8'd0) begin
          w_next_state = S_CHECK;
        end else begin
          w_next_state = S_COUNT;
        end
      end
      S_COUNT: begin
        o_acc_inc = 1'b1;
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == 8'd1) begin
          w_next_state = S_CHECK;
        end else begin
          w_next_state = S_COUNT;
        end
      end
      S_CHECK: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture, step down-counter, and result/err/done registers.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= 8'd0;
      r_ld       <= 8'd0;
      r_expected <= 8'd0;
      r_result   <= 8'd0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_check_ok;
      if (w_accept) begin
        r_ld       <= i_load_val;
        r_cnt      <= i_steps;
        r_expected <= i_load_val + i_steps;
        r_err      <= 1'b0;
      end else if (r_state == S_COUNT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_check_ok) begin
        r_result <= i_acc_op;
        r_err    <= (i_acc_op != r_expected);
      end
    end
  end

  assign o_acc_ip = r_ld;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_err    = r_err;

endmodule
